stack_cmd_issuer: RTL and testbench
===================================

STACK_CMD_ISSUER -- requirements
Module: stack_cmd_issuer

Interface
REQ-001 Parameter DATA_WIDTH SHALL be provided: default 32; width of command data words.
REQ-002 Parameter FIFO_DEPTH SHALL be provided: default 4; number of command buffer entries, power of two.
REQ-003 clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 in_valid SHALL be an input, 1 bit: the producer offers a command.
REQ-006 in_ready SHALL be an output, 1 bit: the block accepts a command this cycle.
REQ-007 in_ctl SHALL be an input, 2 bits: command code (00 drain, 01 half, 10 full, 11 split).
REQ-008 in_data SHALL be an input, DATA_WIDTH bits: command data word.
REQ-009 flush SHALL be an input, 1 bit: discard all buffered commands.
REQ-010 stall SHALL be an input, 1 bit: driven by the wait output of the downstream stack stage.
REQ-011 out_ctl SHALL be an output, 2 bits, registered: command to the stack stage.
REQ-012 out_data SHALL be an output, DATA_WIDTH bits, registered: data to the stack stage.
REQ-013 o_depth SHALL be an output, 2 bits: mirrored downstream stack occupancy (0..3).
REQ-014 o_count SHALL be an output, clog2(FIFO_DEPTH)+1 bits: number of buffered commands.
REQ-015 o_hold SHALL be an output, 1 bit, registered: a split command was withheld this cycle.

Function
REQ-016 in_ready SHALL equal (count < FIFO_DEPTH) && !flush && !rst, and SHALL NOT depend on in_valid.
REQ-017 A push SHALL occur on an edge where in_valid && in_ready; {in_ctl, in_data} are written at the tail.
REQ-018 A command pushed at edge k SHALL appear on out_ctl/out_data no earlier than edge k+1; there is no bypass path.
REQ-019 When stall is high, out_ctl, out_data, o_depth and the FIFO head SHALL hold; pushes are still accepted.
REQ-020 When stall is low and the FIFO is non-empty, and NOT (head ctl = 11 && o_depth = 3), the head SHALL be popped and driven onto out_ctl/out_data.
REQ-021 When stall is low, head ctl = 11 and o_depth = 3, the block SHALL issue out_ctl = 00 with out_data = 0, set o_hold = 1 and keep the head.
REQ-022 When stall is low and the FIFO is empty, the block SHALL issue out_ctl = 00 with out_data = 0.
REQ-023 o_hold SHALL be 0 in every cycle not covered by REQ-021.
REQ-024 On each non-stalled issue, o_depth SHALL update from (depth, issued ctl):
- depth 0: 11 -> 1; otherwise 0.
- depth 1: 00 -> 0; 01/10 -> 1; 11 -> 2.
- depth 2: 00 -> 1; 01/10 -> 2; 11 -> 3.
- depth 3: 00 -> 2; 01/10 -> 3; 11 -> 2.
REQ-025 When a push and a pop occur at the same edge, count SHALL remain unchanged; when full, a push is refused per REQ-016, even if a pop occurs that cycle.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 flush SHALL, at the next edge, zero the pointers and count, and drive out_ctl = 00 and out_data = 0.
REQ-028 flush SHALL update o_depth per REQ-024 with ctl 00, and SHALL take priority over stall, push and pop.

Reset
REQ-029 While rst is high at an edge, the block SHALL clear: count, pointers, o_depth, o_hold, out_ctl, out_data.
REQ-030 in_ready SHALL be 0 during rst and SHALL be 1 in the first cycle after rst deasserts.
REQ-031 rst asserted mid-operation SHALL discard all buffered commands with no partial issue.

Structure
REQ-032 A shared package stack_pkg SHALL hold:
- ctl encodings CTL_DRAIN = 00, CTL_HALF = 01, CTL_FULL = 10, CTL_SPLIT = 11;
- STACK_SIZE = 3;
- the depth transition function of REQ-024.
REQ-033 Buffering SHALL be one sub-module, cmd_fifo, parameterised by width and depth, providing count, push and pop.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Reset, then push {10, 0xDEADBEEF} -> next edge out_ctl = 10, out_data = 0xDEADBEEF, o_depth = 0.
- Push four 11 commands back to back -> o_depth 1, 2, 3; the fourth issues 00 with o_hold = 1, then issues 11 at depth 2.
- Push 5 commands while stall is held high -> in_ready low after 4, o_count = 4, outputs frozen; release stall -> in order drain.
- Full FIFO with simultaneous in_valid and pop -> push refused that cycle, o_count = 3.
- flush with 3 entries buffered and in_valid high -> o_count = 0, out_ctl = 00, push dropped.
- rst mid-stream at depth 2 -> all outputs 0 at the next edge, in_ready = 1 the cycle after.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack command path: ctl encodings, stack size, depth tracking.
package stack_pkg;

  localparam logic [1:0] CTL_DRAIN = 2'b00;
  localparam logic [1:0] CTL_HALF  = 2'b01;
  localparam logic [1:0] CTL_FULL  = 2'b10;
  localparam logic [1:0] CTL_SPLIT = 2'b11;

  localparam int STACK_SIZE = 3;

  // Occupancy of the downstream stack after it consumes one command.
  function automatic logic [1:0] depth_next(input logic [1:0] depth, input logic [1:0] ctl);
    logic [1:0] nxt;
    case (depth)
      2'd0:    nxt = (ctl == CTL_SPLIT) ? 2'd1 : 2'd0;
      2'd1:    nxt = (ctl == CTL_DRAIN) ? 2'd0 : (ctl == CTL_SPLIT) ? 2'd2 : 2'd1;
      2'd2:    nxt = (ctl == CTL_DRAIN) ? 2'd1 : (ctl == CTL_SPLIT) ? 2'd3 : 2'd2;
      default: nxt = (ctl == CTL_HALF || ctl == CTL_FULL) ? 2'd3 : 2'd2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic command FIFO: registered storage, combinational head read, synchronous clear.
// Push is written at the tail on the edge; the caller must not push when full or pop when empty.
module cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly AW bits wide, so the increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stack_cmd_issuer.sv
// Buffers commands and issues one per cycle to the stack stage, withholding splits when the stack is full.
// One-cycle minimum latency (no bypass); stall freezes issue while pushes continue until the buffer fills.
module stack_cmd_issuer
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_ctl,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         flush,
  input  logic                         stall,
  output logic [1:0]                   out_ctl,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [1:0]                   o_depth,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_hold
);

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  withhold;
  logic [DATA_WIDTH+1:0] head;
  logic [1:0]            head_ctl;
  logic [DATA_WIDTH-1:0] head_data;

  assign {head_ctl, head_data} = head;

  assign in_ready = !full && !flush && !rst;
  assign push     = in_valid && in_ready;
  assign empty    = (o_count == '0);
  // A split into a full stack would overflow it; issue a drain instead and retry next cycle.
  assign withhold = !empty && (head_ctl == CTL_SPLIT) && (o_depth == 2'(STACK_SIZE));
  assign pop      = !rst && !flush && !stall && !empty && !withhold;

  cmd_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (push),
    .wr_data ({in_ctl, in_data}),
    .pop     (pop),
    .rd_data (head),
    .count   (o_count),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ctl  <= CTL_DRAIN;
      out_data <= '0;
      o_depth  <= 2'd0;
      o_hold   <= 1'b0;
    end else if (flush) begin
      out_ctl  <= CTL_DRAIN;
      out_data <= '0;
      o_depth  <= depth_next(o_depth, CTL_DRAIN);
      o_hold   <= 1'b0;
    end else if (stall) begin
      o_hold   <= 1'b0;
    end else if (pop) begin
      out_ctl  <= head_ctl;
      out_data <= head_data;
      o_depth  <= depth_next(o_depth, head_ctl);
      o_hold   <= 1'b0;
    end else begin
      out_ctl  <= CTL_DRAIN;
      out_data <= '0;
      o_depth  <= depth_next(o_depth, CTL_DRAIN);
      o_hold   <= withhold;
    end
  end

endmodule

// File: tb/tb_stack_cmd_issuer.sv
// Directed and random bench for stack_cmd_issuer against a queue-based reference model.
module tb_stack_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ctl;
  logic [31:0] in_data;
  logic        flush;
  logic        stall;
  logic [1:0]  out_ctl;
  logic [31:0] out_data;
  logic [1:0]  o_depth;
  logic [2:0]  o_count;
  logic        o_hold;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  c;
    logic [31:0] d;
  } cmd_t;

  cmd_t        q[$];
  logic [1:0]  m_ctl;
  logic [31:0] m_data;
  int          m_depth;
  logic        m_hold;

  always #5 clk = ~clk;

  stack_cmd_issuer #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctl   (in_ctl),
    .in_data  (in_data),
    .flush    (flush),
    .stall    (stall),
    .out_ctl  (out_ctl),
    .out_data (out_data),
    .o_depth  (o_depth),
    .o_count  (o_count),
    .o_hold   (o_hold)
  );

  // Stack occupancy: drain removes one, split adds one (a split on a full stack nets to 2).
  function automatic int mdepth(input int d, input int c);
    if (c == 0) return (d > 0) ? d - 1 : 0;
    if (c == 3) return (d == 3) ? 2 : d + 1;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] c,
                      input logic [31:0] d, input logic fl, input logic st);
    logic rdy;
    cmd_t h;
    rst = r; in_valid = v; in_ctl = c; in_data = d; flush = fl; stall = st;
    #1;
    rdy = (q.size() < 4) && !fl && !r;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (r) begin
      q.delete(); m_ctl = 2'd0; m_data = '0; m_depth = 0; m_hold = 1'b0;
    end else if (fl) begin
      q.delete(); m_ctl = 2'd0; m_data = '0; m_depth = mdepth(m_depth, 0); m_hold = 1'b0;
    end else begin
      if (st) begin
        m_hold = 1'b0;
      end else if (q.size() == 0) begin
        m_ctl = 2'd0; m_data = '0; m_depth = mdepth(m_depth, 0); m_hold = 1'b0;
      end else if (q[0].c == 2'd3 && m_depth == 3) begin
        m_ctl = 2'd0; m_data = '0; m_depth = mdepth(m_depth, 0); m_hold = 1'b1;
      end else begin
        h = q.pop_front();
        m_ctl = h.c; m_data = h.d; m_depth = mdepth(m_depth, int'(h.c)); m_hold = 1'b0;
      end
      if (v && rdy) q.push_back('{c, d});
    end
    @(posedge clk);
    #1;
    chk("out_ctl",  64'(out_ctl),  64'(m_ctl));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("o_depth",  64'(o_depth),  64'(m_depth));
    chk("o_count",  64'(o_count),  64'(q.size()));
    chk("o_hold",   64'(o_hold),   64'(m_hold));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctl = 2'd0; in_data = '0; flush = 1'b0; stall = 1'b0;
    m_ctl = 2'd0; m_data = '0; m_depth = 0; m_hold = 1'b0;
    #1;

    // Reset, then a single FULL command.
    step(1, 0, 2'd0, 32'h0, 0, 0);
    step(1, 0, 2'd0, 32'h0, 0, 0);
    chk("rst_out_ctl", 64'(out_ctl), 64'd0);
    chk("rst_count",   64'(o_count), 64'd0);
    step(0, 1, 2'd2, 32'hDEADBEEF, 0, 0);
    chk("s1_no_bypass", 64'(out_ctl), 64'd0);
    step(0, 0, 2'd0, 32'h0, 0, 0);
    chk("s1_ctl",   64'(out_ctl),  64'd2);
    chk("s1_data",  64'(out_data), 64'hDEADBEEF);
    chk("s1_depth", 64'(o_depth),  64'd0);

    // Four back-to-back splits: the fourth is withheld once at depth 3.
    step(0, 1, 2'd3, 32'h11, 0, 0);
    step(0, 1, 2'd3, 32'h22, 0, 0);
    chk("s2_depth1", 64'(o_depth), 64'd1);
    step(0, 1, 2'd3, 32'h33, 0, 0);
    chk("s2_depth2", 64'(o_depth), 64'd2);
    step(0, 1, 2'd3, 32'h44, 0, 0);
    chk("s2_depth3", 64'(o_depth), 64'd3);
    step(0, 0, 2'd0, 32'h0, 0, 0);
    chk("s2_hold",      64'(o_hold),  64'd1);
    chk("s2_hold_ctl",  64'(out_ctl), 64'd0);
    chk("s2_hold_dep",  64'(o_depth), 64'd2);
    step(0, 0, 2'd0, 32'h0, 0, 0);
    chk("s2_split_ctl", 64'(out_ctl),  64'd3);
    chk("s2_split_dat", 64'(out_data), 64'h44);
    chk("s2_unhold",    64'(o_hold),   64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 32'h0, 0, 0);

    // Fill under stall, then pop on a full buffer with in_valid held high.
    step(0, 1, 2'd1, 32'hA1, 0, 1);
    step(0, 1, 2'd2, 32'hA2, 0, 1);
    step(0, 1, 2'd0, 32'hA3, 0, 1);
    step(0, 1, 2'd1, 32'hA4, 0, 1);
    chk("s3_full_rdy", 64'(in_ready), 64'd0);
    step(0, 1, 2'd2, 32'hA5, 0, 1);
    chk("s3_count", 64'(o_count), 64'd4);
    chk("s3_frozen", 64'(out_ctl), 64'd0);
    step(0, 1, 2'd3, 32'hA6, 0, 0);
    chk("s4_count", 64'(o_count),  64'd3);
    chk("s4_head",  64'(out_data), 64'hA1);
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 32'h0, 0, 0);

    // Flush with three buffered commands and a concurrent push.
    step(0, 1, 2'd2, 32'hB1, 0, 1);
    step(0, 1, 2'd1, 32'hB2, 0, 1);
    step(0, 1, 2'd3, 32'hB3, 0, 1);
    step(0, 1, 2'd2, 32'hB4, 1, 1);
    chk("s5_count", 64'(o_count), 64'd0);
    chk("s5_ctl",   64'(out_ctl), 64'd0);
    step(0, 0, 2'd0, 32'h0, 0, 0);
    chk("s5_dropped", 64'(o_count), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 32'h0, 0, 0);

    // Reset mid-stream at depth 2.
    step(0, 1, 2'd3, 32'hC1, 0, 0);
    step(0, 1, 2'd3, 32'hC2, 0, 0);
    step(0, 1, 2'd1, 32'hC3, 0, 0);
    chk("s6_depth2", 64'(o_depth), 64'd2);
    step(1, 1, 2'd2, 32'hC4, 0, 0);
    chk("s6_rst_ctl",   64'(out_ctl),  64'd0);
    chk("s6_rst_data",  64'(out_data), 64'd0);
    chk("s6_rst_depth", 64'(o_depth),  64'd0);
    chk("s6_rst_count", 64'(o_count),  64'd0);
    step(0, 0, 2'd0, 32'h0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), 1'($urandom_range(1)), 2'($urandom_range(3)), $urandom,
           ($urandom_range(15) == 0), ($urandom_range(3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
